// File: rtl/mult_feed.sv
// mult_feed: operand FIFO, credit-gated issue and result FIFO around a 16-bit multiplier chain.
// Optional MULT_FEED_TAG_EN carries a per-operation tag from request to result.
module mult_feed #(
    parameter int IN_DEPTH  = 4,
    parameter int RES_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_mcand,
    input  logic [15:0]      req_mplier,
`ifdef MULT_FEED_TAG_EN
    input  logic [TAG_W-1:0] req_tag,
    output logic [TAG_W-1:0] res_tag,
`endif
    output logic             start,
    output logic [15:0]      mcand_out,
    output logic [15:0]      mplier_out,
    output logic [15:0]      product_out,
    input  logic             done,
    input  logic [15:0]      product_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_product,
    output logic             err
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [IAW:0] IN_FULL  = IN_DEPTH[IAW:0];
    localparam logic [RAW:0] RES_FULL = RES_DEPTH[RAW:0];
    localparam logic [IAW:0] IN_ONE   = {{IAW{1'b0}}, 1'b1};
    localparam logic [RAW:0] RES_ONE  = {{RAW{1'b0}}, 1'b1};

    logic [15:0]  r_in_mcand  [IN_DEPTH];
    logic [15:0]  r_in_mplier [IN_DEPTH];
    logic [15:0]  r_res_prod  [RES_DEPTH];
    logic [IAW:0] r_in_wr, r_in_rd;
    logic [RAW:0] r_res_wr, r_res_rd, r_credits, r_in_flight;
    logic         r_start, r_err;
    logic [15:0]  r_mcand, r_mplier;
    logic [IAW:0] w_in_count;
    logic [RAW:0] w_res_count;
    logic         w_in_push, w_issue, w_res_pop, w_res_push, w_res_full, w_done_ok;

    assign w_in_count  = r_in_wr - r_in_rd;
    assign w_res_count = r_res_wr - r_res_rd;
    assign req_ready   = w_in_count != IN_FULL;
    assign w_in_push   = req_valid && req_ready;
    assign w_issue     = (w_in_count != '0) && (r_credits != '0);
    assign res_valid   = w_res_count != '0;
    assign w_res_pop   = res_valid && res_ready;
    assign w_res_full  = w_res_count == RES_FULL;
    assign w_done_ok   = done && (r_in_flight != '0);
    // A pop on the same edge frees the slot, so a full FIFO can still take a result.
    assign w_res_push  = w_done_ok && (!w_res_full || w_res_pop);

    assign start       = r_start;
    assign mcand_out   = r_mcand;
    assign mplier_out  = r_mplier;
    assign product_out = '0;
    assign res_product = res_valid ? r_res_prod[r_res_rd[RAW-1:0]] : '0;
    assign err         = r_err;

    always_ff @(posedge clock) begin
        if (w_in_push) begin
            r_in_mcand[r_in_wr[IAW-1:0]]  <= req_mcand;
            r_in_mplier[r_in_wr[IAW-1:0]] <= req_mplier;
        end
        if (w_res_push) r_res_prod[r_res_wr[RAW-1:0]] <= product_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_wr     <= '0;
            r_in_rd     <= '0;
            r_res_wr    <= '0;
            r_res_rd    <= '0;
            r_credits   <= RES_FULL;
            r_in_flight <= '0;
            r_start     <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_in_push) r_in_wr <= r_in_wr + IN_ONE;
            if (w_issue) begin
                r_in_rd  <= r_in_rd + IN_ONE;
                r_mcand  <= r_in_mcand[r_in_rd[IAW-1:0]];
                r_mplier <= r_in_mplier[r_in_rd[IAW-1:0]];
            end
            r_start     <= w_issue;
            if (w_res_push) r_res_wr <= r_res_wr + RES_ONE;
            if (w_res_pop) r_res_rd <= r_res_rd + RES_ONE;
            r_credits   <= r_credits + {{RAW{1'b0}}, w_res_pop} - {{RAW{1'b0}}, w_issue};
            r_in_flight <= r_in_flight + {{RAW{1'b0}}, w_issue} - {{RAW{1'b0}}, w_done_ok};
            r_err       <= r_err | (done && !w_res_push);
        end
    end

`ifdef MULT_FEED_TAG_EN
    logic [TAG_W-1:0] r_in_tag  [IN_DEPTH];
    logic [TAG_W-1:0] r_tq      [RES_DEPTH];
    logic [TAG_W-1:0] r_res_tag [RES_DEPTH];
    logic [RAW-1:0]   r_tq_wr, r_tq_rd;

    always_ff @(posedge clock) begin
        if (w_in_push) r_in_tag[r_in_wr[IAW-1:0]] <= req_tag;
        if (w_issue) r_tq[r_tq_wr] <= r_in_tag[r_in_rd[IAW-1:0]];
        if (w_res_push) r_res_tag[r_res_wr[RAW-1:0]] <= r_tq[r_tq_rd];
    end

    // The tag queue advances on every accepted done, even if the result itself is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tq_wr <= '0;
            r_tq_rd <= '0;
        end else begin
            if (w_issue) r_tq_wr <= r_tq_wr + RES_ONE[RAW-1:0];
            if (w_done_ok) r_tq_rd <= r_tq_rd + RES_ONE[RAW-1:0];
        end
    end

    assign res_tag = res_valid ? r_res_tag[r_res_rd[RAW-1:0]] : '0;
`else
`endif
endmodule

// File: doc/mult_feed.md
Name: mult_feed

Overview:
- Operand front end and result back end for the 16-bit pipelined multiplier chain (chain of multiplier stages, first stage fed, last stage drained).
- Accepts operand pairs over a valid/ready handshake and buffers them in an input FIFO.
- Issues one operation per cycle into the first stage as start plus operands, with product seeded to 0.
- Captures the last stage's done/product into a result FIFO. The chain cannot stall, so issue is credit-gated to guarantee result space.

Parameters:
- IN_DEPTH, 4, input operand FIFO entries (power of 2, >=2).
- RES_DEPTH, 4, result FIFO entries; also the initial credit count (power of 2, >=2).
- TAG_W, 4, tag width (used only with MULT_FEED_TAG_EN).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  operand pair offered.
- req_ready  out  1  input FIFO can accept.
- req_mcand  in  16  multiplicand.
- req_mplier  in  16  multiplier.
- start  out  1  one-cycle issue pulse to first stage.
- mcand_out  out  16  multiplicand to first stage.
- mplier_out  out  16  multiplier to first stage.
- product_out  out  16  product seed to first stage; constant 0.
- done  in  1  result valid from last stage.
- product_in  in  16  result from last stage (low 16 bits of mcand*mplier).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_product  out  16  head result.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, clocked release): both FIFOs empty, credits=RES_DEPTH.
  - Outputs at reset: start=0, mcand_out=0, mplier_out=0, res_valid=0, res_product=0, err=0, req_ready=1.
- Input FIFO push: req_valid && req_ready.
  - req_ready = (in_count != IN_DEPTH), decoded from count only.
  - When full, req_ready=0 even if an issue pops in the same cycle; no same-cycle bypass.
- Issue condition: in FIFO non-empty && credits != 0.
  - On the issuing edge: start<=1, mcand_out/mplier_out <= FIFO head, head popped, credits decremented.
  - Otherwise start<=0 and mcand_out/mplier_out hold their last values.
- Issue rate and latency:
  - Maximum one issue per cycle.
  - Latency from a push at edge E0 to start high is one cycle: start is high after edge E0+1.
  - Back-to-back pushes yield back-to-back start pulses.
- Credits: range 0..RES_DEPTH.
  - Issue decrements; result pop (res_valid && res_ready) increments.
  - Issue and pop in the same cycle leave credits unchanged.
  - Invariant: credits + in_flight + res_count == RES_DEPTH.
- Result capture: done=1 pushes product_in into the result FIFO at that edge.
  - res_valid = !res_empty; res_product = head entry.
  - Push and pop in the same cycle are both allowed, including when full (the pop frees the slot).
- Ordering: results are returned strictly in issue order; pipeline latency is not a parameter of this block.
- Error conditions (err is set and held until reset):
  - done while in_flight == 0: result dropped.
  - done while the result FIFO is full with no simultaneous pop: result dropped.
- Reset mid-operation: in-flight operations are discarded. A done arriving after reset release with in_flight == 0 sets err.
- Pointers: wrap modulo depth; the extra MSB in each count distinguishes full from empty.

Optional Feature:
- Macro: MULT_FEED_TAG_EN.
- Defined:
  - Adds port req_tag (in, TAG_W), stored alongside the operands.
  - On issue, the tag is pushed into an in-flight tag queue of RES_DEPTH entries.
  - On done, the tag is popped and written into the result FIFO with the product.
  - Adds port res_tag (out, TAG_W), the head tag; reset value 0.
  - A spurious done sets err and pops no tag.
- Undefined: no tag ports and no tag storage; behaviour is otherwise identical.

Test Plan:
- Single op: mcand=3, mplier=5, res_ready=1 -> start pulses once with 3/5 one cycle after accept; a later done with product 15 gives res_valid=1, res_product=15 for one cycle; credits return to 4.
- Streaming: 8 pairs (k, k+1) for k=1..8 back-to-back, res_ready=1 -> 8 consecutive start pulses; results 2, 6, 12, 20, 30, 42, 56, 72 in order; err=0.
- Backpressure: res_ready=0, 10 requests offered, RES_DEPTH=IN_DEPTH=4:
  - Exactly 4 starts issue, then start stays 0.
  - The input FIFO fills to 4 and req_ready drops after 8 accepts.
  - Raising res_ready drains all 8 results in order with no loss.
- Simultaneous events: result FIFO full, credits=0, res_ready=1 with a pending input -> pop and issue occur on consecutive edges; a done concurrent with a pop on a full FIFO is accepted; credits never exceed 4.
- Reset mid-operation: assert reset with 3 ops in flight -> all outputs reach reset values immediately. Injecting done after release -> err=1 and res_valid stays 0.
- Tag (MULT_FEED_TAG_EN): tags 0xA, 0x3, 0x7 with operands (2,2), (3,3), (4,4) -> results 4/0xA, 9/0x3, 16/0x7.
